// File: rtl/branch_issue_ctrl.sv
// branch_issue_ctrl: reservation station and sequencer for the single branch unit.
// Branches wait here until both operand tags are ready. One ready branch is issued
// at a time, and the unit's result request is held until the CDB arbiter grants it.
// Optional build macro BR_AGE_SELECT_EN: when defined, the oldest ready entry
// relative to rob_head is selected. When undefined, the lowest-index ready entry
// is selected and rob_head is unused.
module branch_issue_ctrl #(
    parameter int RS_SIZE = 4,
    parameter int ROB_LEN = 5,
    parameter int PRF_LEN = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic [ROB_LEN-1:0] alloc_rob_idx,
    input  logic [PRF_LEN-1:0] alloc_src1_preg,
    input  logic               alloc_src1_rdy,
    input  logic [PRF_LEN-1:0] alloc_src2_preg,
    input  logic               alloc_src2_rdy,
    input  logic               cdb_valid,
    input  logic [PRF_LEN-1:0] cdb_preg,
    input  logic [ROB_LEN-1:0] rob_head,
    output logic               issue_valid,
    output logic [ROB_LEN-1:0] issue_rob_idx,
    output logic [PRF_LEN-1:0] issue_src1_preg,
    output logic [PRF_LEN-1:0] issue_src2_preg,
    output logic               br_result_req,
    output logic [ROB_LEN-1:0] br_result_rob_idx,
    input  logic               cdb_grant
);

    localparam int IDX_W = $clog2(RS_SIZE);

    typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;

    state_t               state_q, state_d;
    logic [ROB_LEN-1:0]   resRob_q, resRob_d;
    logic [RS_SIZE-1:0]   valid_q, valid_d;
    logic [RS_SIZE-1:0]   src1Rdy_q, src1Rdy_d;
    logic [RS_SIZE-1:0]   src2Rdy_q, src2Rdy_d;
    logic [ROB_LEN-1:0]   robIdx_q [RS_SIZE];
    logic [ROB_LEN-1:0]   robIdx_d [RS_SIZE];
    logic [PRF_LEN-1:0]   src1Tag_q [RS_SIZE];
    logic [PRF_LEN-1:0]   src1Tag_d [RS_SIZE];
    logic [PRF_LEN-1:0]   src2Tag_q [RS_SIZE];
    logic [PRF_LEN-1:0]   src2Tag_d [RS_SIZE];

    logic [RS_SIZE-1:0]   cand;
    logic                 freeFound;
    logic [IDX_W-1:0]     freeIdx;
    logic                 selFound;
    logic [IDX_W-1:0]     selIdx;
    logic                 issueFire;

    assign cand        = valid_q & src1Rdy_q & src2Rdy_q;
    assign alloc_ready = ~(&valid_q);

    // Lowest-index free slot receives the next dispatched branch.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

`ifdef BR_AGE_SELECT_EN
    logic [ROB_LEN-1:0] age [RS_SIZE];
    logic [ROB_LEN-1:0] bestAge;

    // Oldest ready entry wins; age is the ROB distance from the current head.
    always_comb begin
        selFound = 1'b0;
        selIdx   = '0;
        bestAge  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            age[i] = robIdx_q[i] - rob_head;
            if (cand[i] && (!selFound || (age[i] < bestAge))) begin
                selFound = 1'b1;
                selIdx   = IDX_W'(i);
                bestAge  = age[i];
            end
        end
    end
`else
    logic unusedRobHead;
    assign unusedRobHead = ^rob_head;

    // Lowest-index ready entry wins; no age comparison is needed.
    always_comb begin
        selFound = 1'b0;
        selIdx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i]) begin
                selFound = 1'b1;
                selIdx   = IDX_W'(i);
            end
        end
    end
`endif

    assign issueFire = !squash && selFound &&
                       ((state_q == IDLE) || ((state_q == RESULT) && cdb_grant));

    assign issue_valid       = issueFire;
    assign issue_rob_idx     = issueFire ? robIdx_q[selIdx]  : '0;
    assign issue_src1_preg   = issueFire ? src1Tag_q[selIdx] : '0;
    assign issue_src2_preg   = issueFire ? src2Tag_q[selIdx] : '0;
    assign br_result_req     = (state_q == RESULT);
    assign br_result_rob_idx = resRob_q;

    // Entry update: squash flush, CDB wakeup, release of the issued entry, allocation.
    always_comb begin
        valid_d   = valid_q;
        src1Rdy_d = src1Rdy_q;
        src2Rdy_d = src2Rdy_q;
        robIdx_d  = robIdx_q;
        src1Tag_d = src1Tag_q;
        src2Tag_d = src2Tag_q;
        if (squash) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i] && cdb_valid && (src1Tag_q[i] == cdb_preg)) begin
                    src1Rdy_d[i] = 1'b1;
                end
                if (valid_q[i] && cdb_valid && (src2Tag_q[i] == cdb_preg)) begin
                    src2Rdy_d[i] = 1'b1;
                end
                if (issueFire && (selIdx == IDX_W'(i))) begin
                    valid_d[i] = 1'b0;
                end
            end
            if (alloc_valid && freeFound) begin
                valid_d[freeIdx]   = 1'b1;
                robIdx_d[freeIdx]  = alloc_rob_idx;
                src1Tag_d[freeIdx] = alloc_src1_preg;
                src2Tag_d[freeIdx] = alloc_src2_preg;
                src1Rdy_d[freeIdx] = alloc_src1_rdy || (cdb_valid && (cdb_preg == alloc_src1_preg));
                src2Rdy_d[freeIdx] = alloc_src2_rdy || (cdb_valid && (cdb_preg == alloc_src2_preg));
            end
        end
    end

    // Branch unit sequencing: issue, one execute cycle, then hold the request until granted.
    always_comb begin
        state_d  = state_q;
        resRob_d = resRob_q;
        case (state_q)
            IDLE:    if (issueFire) state_d = EXEC;
            EXEC:    state_d = RESULT;
            RESULT:  if (cdb_grant) state_d = issueFire ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
        if (issueFire) begin
            resRob_d = robIdx_q[selIdx];
        end
        if (squash) begin
            state_d = IDLE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            resRob_q  <= '0;
            valid_q   <= '0;
            src1Rdy_q <= '0;
            src2Rdy_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                robIdx_q[i]  <= '0;
                src1Tag_q[i] <= '0;
                src2Tag_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            resRob_q  <= resRob_d;
            valid_q   <= valid_d;
            src1Rdy_q <= src1Rdy_d;
            src2Rdy_q <= src2Rdy_d;
            robIdx_q  <= robIdx_d;
            src1Tag_q <= src1Tag_d;
            src2Tag_q <= src2Tag_d;
        end
    end

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// tb_branch_issue_ctrl: directed scenarios followed by random traffic, all compared
// each cycle against a slot-array reference model of the scheduler.
module tb_branch_issue_ctrl;

    localparam int RS_SIZE = 4;
    localparam int ROB_LEN = 5;
    localparam int PRF_LEN = 6;
    localparam int ROBN    = 1 << ROB_LEN;

    logic               clock = 1'b0;
    logic               reset, squash, cdb_grant;
    logic               alloc_valid, alloc_ready;
    logic [ROB_LEN-1:0] alloc_rob_idx, rob_head, issue_rob_idx, br_result_rob_idx;
    logic [PRF_LEN-1:0] alloc_src1_preg, alloc_src2_preg, cdb_preg;
    logic [PRF_LEN-1:0] issue_src1_preg, issue_src2_preg;
    logic               alloc_src1_rdy, alloc_src2_rdy, cdb_valid;
    logic               issue_valid, br_result_req;

    int checks = 0;
    int errors = 0;

    // Reference model: one record per slot plus the branch unit's progress.
    bit mValid [RS_SIZE];
    int mRob   [RS_SIZE];
    int mT1    [RS_SIZE];
    int mT2    [RS_SIZE];
    bit mR1    [RS_SIZE];
    bit mR2    [RS_SIZE];
    int unitStage;   // 0 free, 1 executing, 2 waiting for CDB grant
    int unitRob;
    int robNext;

    branch_issue_ctrl #(.RS_SIZE(RS_SIZE), .ROB_LEN(ROB_LEN), .PRF_LEN(PRF_LEN)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_idx(alloc_rob_idx),
        .alloc_src1_preg(alloc_src1_preg), .alloc_src1_rdy(alloc_src1_rdy),
        .alloc_src2_preg(alloc_src2_preg), .alloc_src2_rdy(alloc_src2_rdy),
        .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .rob_head(rob_head),
        .issue_valid(issue_valid), .issue_rob_idx(issue_rob_idx),
        .issue_src1_preg(issue_src1_preg), .issue_src2_preg(issue_src2_preg),
        .br_result_req(br_result_req), .br_result_rob_idx(br_result_rob_idx),
        .cdb_grant(cdb_grant)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < RS_SIZE; i++) mValid[i] = 1'b0;
        unitStage = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic applyStimulus(input bit aV, input int aRob, input int t1, input bit r1,
                                 input int t2, input bit r2, input bit cV, input int cP,
                                 input int head, input bit gr, input bit sq, input bit doCheck);
        bit expReady, selFound, expIssue;
        int selI, bestAge, age, freeI;
        @(negedge clock);
        alloc_valid     = aV;
        alloc_rob_idx   = ROB_LEN'(aRob);
        alloc_src1_preg = PRF_LEN'(t1);
        alloc_src1_rdy  = r1;
        alloc_src2_preg = PRF_LEN'(t2);
        alloc_src2_rdy  = r2;
        cdb_valid       = cV;
        cdb_preg        = PRF_LEN'(cP);
        rob_head        = ROB_LEN'(head);
        cdb_grant       = gr;
        squash          = sq;
        #1;
        expReady = 1'b0;
        freeI    = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!mValid[i]) begin
                expReady = 1'b1;
                if (freeI < 0) freeI = i;
            end
        end
        selFound = 1'b0;
        selI     = 0;
        bestAge  = 1 << 30;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (mValid[i] && mR1[i] && mR2[i]) begin
`ifdef BR_AGE_SELECT_EN
                age = (mRob[i] - head + ROBN) % ROBN;
`else
                age = i;
`endif
                if (age < bestAge) begin
                    bestAge  = age;
                    selI     = i;
                    selFound = 1'b1;
                end
            end
        end
        expIssue = !sq && selFound && (unitStage == 0 || (unitStage == 2 && gr));
        if (doCheck && !reset) begin
            checkOutput("alloc_ready", 32'(alloc_ready), 32'(expReady));
            checkOutput("issue_valid", 32'(issue_valid), 32'(expIssue));
            if (expIssue) begin
                checkOutput("issue_rob_idx", 32'(issue_rob_idx), 32'(mRob[selI]));
                checkOutput("issue_src1", 32'(issue_src1_preg), 32'(mT1[selI]));
                checkOutput("issue_src2", 32'(issue_src2_preg), 32'(mT2[selI]));
            end
            checkOutput("br_result_req", 32'(br_result_req), 32'(unitStage == 2));
            if (unitStage == 2) checkOutput("br_result_rob_idx", 32'(br_result_rob_idx), 32'(unitRob));
        end
        @(posedge clock);
        if (reset || sq) begin
            modelClear();
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (mValid[i] && cV && mT1[i] == cP) mR1[i] = 1'b1;
                if (mValid[i] && cV && mT2[i] == cP) mR2[i] = 1'b1;
            end
            if (expIssue) begin
                mValid[selI] = 1'b0;
                unitRob      = mRob[selI];
                unitStage    = 1;
            end else if (unitStage == 1) begin
                unitStage = 2;
            end else if (unitStage == 2 && gr) begin
                unitStage = 0;
            end
            if (aV && expReady) begin
                mValid[freeI] = 1'b1;
                mRob[freeI]   = aRob % ROBN;
                mT1[freeI]    = t1;
                mT2[freeI]    = t2;
                mR1[freeI]    = r1 || (cV && cP == t1);
                mR2[freeI]    = r2 || (cV && cP == t2);
            end
        end
    endtask

    // Shorthand for a cycle with no allocation and no broadcast.
    task automatic idleCycle(input bit gr);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, gr, 0, 1);
    endtask

    initial begin
        bit aV, cV, gr, sq, r1, r2;
        modelClear();
        unitRob = 0;
        robNext = 0;
        reset   = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Reset state of every output.
        @(negedge clock);
        #1;
        checkOutput("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        checkOutput("reset_issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("reset_issue_rob", 32'(issue_rob_idx), 32'd0);
        checkOutput("reset_result_req", 32'(br_result_req), 32'd0);
        checkOutput("reset_result_rob", 32'(br_result_rob_idx), 32'd0);

        // Ready branch issues next cycle; result held until the grant.
        applyStimulus(1, 3, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) idleCycle(0);
        idleCycle(1);
        idleCycle(0);

        // Wakeup: a non-matching tag does nothing, the matching tag enables issue.
        applyStimulus(1, 7, 12, 0, 5, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 13, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) idleCycle(0);
        idleCycle(1);

        // Age selection across the ROB wrap with rob_head=30.
        applyStimulus(1, 2, 20, 0, 20, 0, 0, 0, 30, 0, 0, 1);
        applyStimulus(1, 31, 20, 0, 20, 0, 0, 0, 30, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 20, 30, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 30, 0, 0, 1);

        // Fill to full, overflow attempt, back-to-back issue under grant, then squash in EXEC.
        applyStimulus(1, 10, 40, 0, 41, 0, 0, 0, 30, 0, 0, 1);
        applyStimulus(1, 11, 40, 0, 41, 0, 0, 0, 30, 0, 0, 1);
        applyStimulus(1, 12, 42, 0, 42, 0, 1, 40, 30, 0, 0, 1);
        applyStimulus(1, 13, 40, 1, 41, 1, 1, 41, 30, 1, 0, 1);
        applyStimulus(1, 14, 1, 1, 1, 1, 0, 0, 30, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 30, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 30, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 30, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 30, 1, 0, 1);
        idleCycle(0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            aV = ($urandom_range(0, 99) < 60);
            cV = ($urandom_range(0, 99) < 50);
            gr = ($urandom_range(0, 99) < 50);
            sq = ($urandom_range(0, 99) < 3);
            r1 = ($urandom_range(0, 99) < 40);
            r2 = ($urandom_range(0, 99) < 40);
            applyStimulus(aV, robNext, int'($urandom_range(0, 7)), r1, int'($urandom_range(0, 7)), r2,
                          cV, int'($urandom_range(0, 7)), int'($urandom_range(0, ROBN - 1)), gr, sq, 1);
            if (aV) robNext = (robNext + 1) % ROBN;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_issue_ctrl.md
Name: branch_issue_ctrl

Overview:
Scheduler in front of the branch execution unit.
- Holds up to RS_SIZE dispatched branches and tracks operand readiness by snooping CDB tags.
- Selects one ready branch at a time, sequences it through the single branch unit, and holds its result request until the CDB arbiter grants it.
- Sits between dispatch/rename, the branch unit, and the CDB arbiter.

Parameters:
RS_SIZE, 4, number of branch entries (power of 2, >=2)
ROB_LEN, 5, ROB index width
PRF_LEN, 6, physical register tag width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
squash  in  1  mispredict/exception flush
alloc_valid  in  1  dispatch presents a branch
alloc_ready  out  1  free entry exists
alloc_rob_idx  in  ROB_LEN  ROB index of the branch
alloc_src1_preg  in  PRF_LEN  tag of operand 1
alloc_src1_rdy  in  1  operand 1 already available
alloc_src2_preg  in  PRF_LEN  tag of operand 2
alloc_src2_rdy  in  1  operand 2 already available
cdb_valid  in  1  CDB broadcast this cycle
cdb_preg  in  PRF_LEN  broadcast tag
rob_head  in  ROB_LEN  current ROB head, used for age
issue_valid  out  1  one-cycle pulse: branch sent to branch unit
issue_rob_idx  out  ROB_LEN  ROB index of the issued branch
issue_src1_preg  out  PRF_LEN  operand 1 tag, for PRF read
issue_src2_preg  out  PRF_LEN  operand 2 tag, for PRF read
br_result_req  out  1  branch unit result awaits the CDB
br_result_rob_idx  out  ROB_LEN  ROB index of the pending result
cdb_grant  in  1  CDB arbiter grants the branch result this cycle

Behaviour:
Reset and squash
- Reset: all entries invalid; FSM in IDLE; every output 0 except alloc_ready=1.
- Squash has identical effect at the next edge and dominates all other events: alloc, wakeup and issue are ignored that cycle, and a pending result is dropped.

Entries
- Each entry holds valid, rob_idx, src1/src2 tag, src1/src2 rdy.
- alloc_ready = any entry invalid, computed from current state only (no same-cycle issue bypass).
- Allocation into the lowest-index free entry when alloc_valid && alloc_ready.
- Wakeup: on cdb_valid, every valid entry with a matching tag sets that rdy bit.
- The allocating entry also wakes if cdb_preg matches its tag in the same cycle.
- Both sources may match the same tag.

Selection and issue
- Candidate = valid && src1_rdy && src2_rdy, using the state before this cycle's wakeup.
- Default select: oldest candidate, with age = (rob_idx - rob_head) mod 2^ROB_LEN; smallest age wins; ties impossible.
- Issue permitted when FSM==IDLE, or FSM==RESULT && cdb_grant (back-to-back).
- On issue: issue_valid=1 for one cycle with the entry's fields (combinational from the selected entry); the entry is freed at the edge.
- A freed entry may be reallocated the following cycle.

FSM
- IDLE -> EXEC on issue.
- EXEC -> RESULT unconditionally (branch unit has 1-cycle latency); br_result_rob_idx is latched at issue.
- RESULT: br_result_req=1 and held stable until cdb_grant.
- On grant: RESULT -> EXEC if a new issue occurs that cycle, else -> IDLE.
- cdb_grant outside RESULT is ignored.

Latency
- Entry allocated ready at cycle N issues at N+1 at the earliest; br_result_req rises at N+3.
- An operand woken at cycle N allows issue at N+1.

Optional Feature:
BR_AGE_SELECT_EN
- Defined: oldest-first selection as above.
- Undefined: the lowest-index ready entry is selected; rob_head is ignored (may be left unconnected); no subtractors are built.

Test Plan:
1. Reset, then alloc rob=3 with both srcs ready at cycle 1 -> issue_valid at cycle 2 with issue_rob_idx=3; br_result_req=1 at cycle 4; held while cdb_grant=0; cleared the cycle after the grant.
2. Alloc rob=7 with src1 tag 12 not ready; cdb_valid with cdb_preg=12 at cycle 5 -> issue at cycle 6; cdb_preg=13 instead -> no issue.
3. With BR_AGE_SELECT_EN defined and rob_head=30: ready entries rob=2 (slot0) and rob=31 (slot1) -> rob=31 issues first. Undefined -> rob=2 issues first.
4. Fill 4 entries -> alloc_ready=0. An issue that cycle does not raise alloc_ready until the next cycle. alloc_valid while full -> no entry is corrupted.
5. In RESULT with cdb_grant=1 and another ready entry -> issue_valid in the same cycle, then EXEC and RESULT follow with no IDLE gap.
6. Squash while in EXEC with 3 valid entries -> next cycle all entries invalid, br_result_req stays 0, alloc_ready=1, and no issue occurs.
